// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state encoding shared by the ALU stage
package alu_pkg;
  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_SUB = 2;
  localparam int unsigned OP_AND = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_XOR = 5;
  localparam int unsigned OP_SHL = 6;
  localparam int unsigned OP_SHR = 7;
  localparam int unsigned OP_MUL = 8;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
  typedef logic [3:0] flags_t;
  function automatic flags_t mk_flags(input logic z, input logic n, input logic c, input logic v);
    flags_t f;
    f = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per cycle.
// done is asserted during the last iteration; product then already includes that step.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage with valid/ready handshake and {V,C,N,Z} flags.
// Define ALU_MUL_EN to add the WIDTH-cycle unsigned multiplier on opcode 8.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]    op1,
  input  logic [WIDTH-1:0]    op2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic [3:0]          flags
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH:0]     sum, diff, shl_w, shr_w;
  logic [SW-1:0]      amt;
  logic [WIDTH-1:0]   res, mul_out;
  logic               c, v, accept, mul_start, mul_done, mul_c;
  flags_t             res_fl, mul_fl;
  assign accept = in_valid && in_ready;
  // One spare bit on each side of the operand catches the last bit shifted out.
  always_comb begin
    amt   = op2[SW-1:0];
    sum   = {1'b0, op1} + {1'b0, op2};
    diff  = {1'b0, op1} - {1'b0, op2};
    shl_w = {1'b0, op1} << amt;
    shr_w = {op1, 1'b0} >> amt;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (alu_op)
      OP_WIDTH'(OP_ADD): begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_WIDTH'(OP_SUB): begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_WIDTH'(OP_AND): res = op1 & op2;
      OP_WIDTH'(OP_OR):  res = op1 | op2;
      OP_WIDTH'(OP_XOR): res = op1 ^ op2;
      OP_WIDTH'(OP_SHL): begin
        res = shl_w[WIDTH-1:0];
        c   = shl_w[WIDTH];
      end
      OP_WIDTH'(OP_SHR): begin
        res = shr_w[WIDTH:1];
        c   = shr_w[0];
      end
      default: res = '0;
    endcase
    res_fl = mk_flags(res == '0, res[WIDTH-1], c, v);
    mul_fl = mk_flags(mul_out == '0, mul_out[WIDTH-1], mul_c, 1'b0);
  end
`ifdef ALU_MUL_EN
  logic [0:0]         state;
  logic [2*WIDTH-1:0] prod;
  assign mul_start = accept && alu_op == OP_WIDTH'(OP_MUL);
  assign in_ready  = state == ST_IDLE && (!out_valid || out_ready);
  assign mul_out   = prod[WIDTH-1:0];
  assign mul_c     = |prod[2*WIDTH-1:WIDTH];
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else if (mul_start) state <= ST_MUL;
    else if (mul_done) state <= ST_IDLE;
  end
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign in_ready  = !out_valid || out_ready;
  assign mul_out   = '0;
  assign mul_c     = 1'b0;
`endif
  // The output register is always empty when the multiplier finishes, so done may load unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out       <= mul_out;
      flags     <= mul_fl;
      out_valid <= 1'b1;
    end else if (accept && !mul_start) begin
      out       <= res;
      flags     <= res_fl;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=8) against an arithmetic reference model.
// Define ALU_MUL_EN to also exercise the multiplier and mid-multiply reset.
module tb_alu_pipe;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic       in_ready, out_valid;
  logic [3:0] alu_op = 0, flags;
  logic [7:0] op1 = 0, op2 = 0, out;
  int         n_checks = 0, n_pass = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .OP_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  // Returns {V,C,N,Z,out} computed with integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua = a;
    int ub = b;
    int sa = a[7] ? ua - 256 : ua;
    int sb = b[7] ? ub - 256 : ub;
    int amt = ub % 8;
    int r = 0;
    bit cy = 0, ov = 0;
    logic [7:0] o;
    case (op)
      4'd1: begin r = ua + ub; cy = r > 255; ov = (sa + sb > 127) || (sa + sb < -128); end
      4'd2: begin r = ua - ub; cy = ua < ub; ov = (sa - sb > 127) || (sa - sb < -128); end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: begin r = ua << amt; cy = amt != 0 && ((ua >> (8 - amt)) & 1) == 1; end
      4'd7: begin r = ua >> amt; cy = amt != 0 && ((ua >> (amt - 1)) & 1) == 1; end
`ifdef ALU_MUL_EN
      4'd8: begin r = ua * ub; cy = r > 255; end
`endif
      default: r = 0;
    endcase
    o = r[7:0];
    return {ov, cy, o[7], o == 8'd0, o};
  endfunction

  // Called at posedge+2; returns at posedge+2 right after the transfer edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    alu_op = op; op1 = a; op2 = b; in_valid = 1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #2;
    in_valid = 0; alu_op = $urandom; op1 = $urandom; op2 = $urandom;
  endtask

  task automatic test_reset;
    in_valid = 1; alu_op = 1; op1 = 8'd5; op2 = 8'd6;
    #3;
    n_checks++;
    if ({in_ready, out_valid, out, flags} !== {1'b1, 1'b0, 8'h00, 4'h0})
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h flags=%b, required 1 0 00 0000", in_ready, out_valid, out, flags);
    else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({out_valid, out} !== {1'b0, 8'h00})
      $display("FAIL reset_hold: out_valid=%b out=%h, required 0 00", out_valid, out);
    else n_pass++;
    in_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_directed;
    logic [31:0] tbl [0:10] = '{32'h1C8642C4, 32'h16464C8A, 32'h20507FE6, 32'h55A5A001,
                                32'h68101024, 32'h70101005, 32'h68108812, 32'h01234001,
                                32'hF7733001, 32'h3F03C300, 32'h48001812};
    logic [31:0] e;
    out_ready = 1;
    for (int i = 0; i < 11; i++) begin
      e = tbl[i];
      issue(e[31:28], e[27:20], e[19:12]);
      n_checks++;
      if ({out_valid, flags, out} !== {1'b1, e[3:0], e[11:4]})
        $display("FAIL directed_%0d op=%h: valid=%b flags=%b out=%h, required 1 %b %h", i, e[31:28], out_valid, flags, out, e[3:0], e[11:4]);
      else n_pass++;
      @(posedge clk); #2;
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL one_cycle_valid_%0d: out_valid=%b, required 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
    issue(4'd1, 8'd1, 8'd1);
    alu_op = 4'd1; op1 = 8'd2; op2 = 8'd2; in_valid = 1;
    #0;
    n_checks++;
    if ({out_valid, out, in_ready} !== {1'b1, 8'd2, 1'b0})
      $display("FAIL bp_first: valid=%b out=%h in_ready=%b, required 1 02 0", out_valid, out, in_ready);
    else n_pass++;
    repeat (2) begin
      @(posedge clk); #2;
    end
    n_checks++;
    if ({out_valid, out, in_ready} !== {1'b1, 8'd2, 1'b0})
      $display("FAIL bp_hold: valid=%b out=%h in_ready=%b, required 1 02 0", out_valid, out, in_ready);
    else n_pass++;
    out_ready = 1;
    #0;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready);
    else n_pass++;
    @(posedge clk); #2;
    in_valid = 0;
    n_checks++;
    if ({out_valid, out} !== {1'b1, 8'd4})
      $display("FAIL bp_second: valid=%b out=%h, required 1 04", out_valid, out);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random;
    int got = 0, cyc = 0;
    logic [11:0] e;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [3:0] op;
          logic [7:0] a, b;
          op = $urandom; a = $urandom; b = $urandom;
          issue(op, a, b);
          exp_q.push_back(model(op, a, b));
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #2;
          end
        end
      end
      begin
        while (got < 60 && cyc < 4000) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            got++;
            n_checks++;
            if (exp_q.size() == 0)
              $display("FAIL rand_extra: unexpected out=%h flags=%b, required no output", out, flags);
            else begin
              e = exp_q.pop_front();
              if ({flags, out} !== e)
                $display("FAIL rand_%0d: flags=%b out=%h, required %b %h", got, flags, out, e[11:8], e[7:0]);
              else n_pass++;
            end
          end
        end
      end
    join
    out_ready = 1;
    if (got < 60) begin
      n_checks++;
      $display("FAIL rand_timeout: received %0d results, required 60", got);
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rand_leftover: out_valid=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    else n_pass++;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    logic [7:0] a [0:1] = '{8'd15, 8'd16};
    logic [7:0] b [0:1] = '{8'd17, 8'd16};
    logic [11:0] x [0:1] = '{{4'b0010, 8'd255}, {4'b0101, 8'd0}};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      int busy = 0;
      issue(4'd8, a[i], b[i]);
      while (!out_valid && busy < 50) begin
        if (!in_ready) busy++;
        @(posedge clk); #2;
      end
      n_checks++;
      if (busy != 8)
        $display("FAIL mul_latency_%0d: busy cycles=%0d, required 8", i, busy);
      else n_pass++;
      n_checks++;
      if ({out_valid, flags, out} !== {1'b1, x[i]})
        $display("FAIL mul_result_%0d: valid=%b flags=%b out=%h, required 1 %b %h", i, out_valid, flags, out, x[i][11:8], x[i][7:0]);
      else n_pass++;
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_mul;
    int seen = 0;
    out_ready = 1;
    issue(4'd1, 8'd9, 8'd9);
    issue(4'd8, 8'd15, 8'd17);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({out_valid, out, flags, in_ready} !== {1'b0, 8'h00, 4'h0, 1'b1})
      $display("FAIL midmul_reset: valid=%b out=%h flags=%b in_ready=%b, required 0 00 0000 1", out_valid, out, flags, in_ready);
    else n_pass++;
    @(posedge clk); #2;
    rst_n = 1;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL midmul_ready: in_ready=%b, required 1", in_ready);
    else n_pass++;
    issue(4'd1, 8'd3, 8'd4);
    n_checks++;
    if ({out_valid, flags, out} !== {1'b1, 4'h0, 8'd7})
      $display("FAIL midmul_add: valid=%b flags=%b out=%h, required 1 0000 07", out_valid, flags, out);
    else n_pass++;
    repeat (12) begin
      @(posedge clk); #2;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0)
      $display("FAIL midmul_ghost: extra valid cycles=%0d, required 0", seen);
    else n_pass++;
  endtask
`else
  task automatic test_op8;
    out_ready = 1;
    issue(4'd8, 8'd3, 8'd5);
    n_checks++;
    if ({out_valid, flags, out} !== {1'b1, 4'b0001, 8'h00})
      $display("FAIL op8_undefined: valid=%b flags=%b out=%h, required 1 0001 00", out_valid, flags, out);
    else n_pass++;
    @(posedge clk); #2;
  endtask
`endif

  initial begin
    test_reset();
    @(posedge clk); #2;
    test_directed();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_op8();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
